// File: rtl/loader_pkg.sv
// Shared types and sizing helpers for the instruction loader.
package loader_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StData,
      StCheck,
      StDone,
      StError
   } state_e;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned BYTE_IDX_W     = 2;

   function automatic int unsigned bytes_per_word(input int unsigned data_w);
      return data_w / 8;
   endfunction

   function automatic int unsigned byte_idx_width(input int unsigned data_w);
      return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
   endfunction

endpackage

// File: rtl/instruction_loader_packer.sv
// Packs an MSB-first byte stream into words and keeps a running XOR of the bytes.
module instruction_loader_packer
   import loader_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic              shift_i,
   input  logic [7:0]        byte_i,
   output logic [DATA_W-1:0] word_o,
   output logic              word_ready_o,
   output logic [7:0]        xor_o
);

   localparam int unsigned Bpw  = bytes_per_word(DATA_W);
   localparam int unsigned IdxW = byte_idx_width(DATA_W);

   logic [DATA_W-1:0] shift_q;
   logic [IdxW-1:0]   idx_q;
   logic [7:0]        xor_q;
   logic              last_byte;

   // word_o is the word as it stands once the current byte is shifted in.
   assign last_byte    = (idx_q == IdxW'(Bpw - 1));
   assign word_o       = (shift_q << 8) | DATA_W'(byte_i);
   assign word_ready_o = shift_i && last_byte;
   assign xor_o        = xor_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shift_q <= '0;
         idx_q   <= '0;
         xor_q   <= '0;
      end else if (clear_i) begin
         shift_q <= '0;
         idx_q   <= '0;
         xor_q   <= '0;
      end else if (shift_i) begin
         shift_q <= word_o;
         xor_q   <= xor_q ^ byte_i;
         idx_q   <= last_byte ? '0 : idx_q + IdxW'(1);
      end
   end

endmodule

// File: rtl/instruction_loader.sv
// Loads a counted, checksummed byte frame into instruction memory and releases the CPU.
module instruction_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_data_i,
   input  logic              restart_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              cpu_hold_o,
   output logic              load_done_o,
   output logic              load_error_o,
   output logic [ADDR_W:0]   words_loaded_o
);

   state_e            state_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              cpu_hold_q;
   logic              load_done_q;
   logic              load_error_q;
   logic [ADDR_W:0]   words_q;
   logic [7:0]        count_q;

   logic              count_bad;
   logic              last_pulse;
   logic              chk_in_data;
   logic              shift;
   logic              clear;
   logic              word_ready;
   logic [DATA_W-1:0] word;
   logic [7:0]        xor_val;

   assign count_bad = (byte_data_i == 8'd0) ||
                      ((64'(BASE_ADDR) + 64'(byte_data_i)) > (64'd1 << ADDR_W));
   // The final word's write pulse is on; a byte now is already the checksum.
   assign last_pulse  = mem_we_q && ((32'(words_q) + 32'd1) == 32'(count_q));
   assign chk_in_data = (state_q == StData) && last_pulse && byte_valid_i;
   assign shift       = !restart_i && (state_q == StData) && byte_valid_i && !last_pulse;
   assign clear       = restart_i || (state_q == StIdle);

   instruction_loader_packer #(
      .DATA_W(DATA_W)
   ) u_packer (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (clear),
      .shift_i     (shift),
      .byte_i      (byte_data_i),
      .word_o      (word),
      .word_ready_o(word_ready),
      .xor_o       (xor_val)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= ADDR_W'(BASE_ADDR);
         mem_wdata_q  <= '0;
         cpu_hold_q   <= 1'b1;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
         words_q      <= '0;
         count_q      <= '0;
      end else if (restart_i) begin
         state_q      <= StIdle;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= ADDR_W'(BASE_ADDR);
         cpu_hold_q   <= 1'b1;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
         words_q      <= '0;
         count_q      <= '0;
      end else begin
         mem_we_q <= word_ready;
         if (word_ready) mem_wdata_q <= word;
         if (mem_we_q) begin
            mem_addr_q <= mem_addr_q + ADDR_W'(1);
            words_q    <= words_q + (ADDR_W + 1)'(1);
         end
         unique case (state_q)
            StIdle: begin
               if (byte_valid_i) begin
                  count_q <= byte_data_i;
                  if (count_bad) begin
                     state_q      <= StError;
                     load_error_q <= 1'b1;
                  end else begin
                     state_q <= StData;
                  end
               end
            end
            StData, StCheck: begin
               if (chk_in_data || (state_q == StCheck && byte_valid_i)) begin
                  if (byte_data_i == xor_val) begin
                     state_q     <= StDone;
                     load_done_q <= 1'b1;
                     cpu_hold_q  <= 1'b0;
                  end else begin
                     state_q      <= StError;
                     load_error_q <= 1'b1;
                  end
               end else if (state_q == StData && last_pulse) begin
                  state_q <= StCheck;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_we_o       = mem_we_q;
   assign mem_addr_o     = mem_addr_q;
   assign mem_wdata_o    = mem_wdata_q;
   assign cpu_hold_o     = cpu_hold_q;
   assign load_done_o    = load_done_q;
   assign load_error_o   = load_error_q;
   assign words_loaded_o = words_q;

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer side of the instruction memory that the instruction fetcher reads.
- Accepts a byte stream from the host link, packs bytes into 32-bit instruction words and writes them sequentially into instruction memory.
- Holds the processor in reset until a complete, checksum-verified program is loaded.
- Sits between the byte-receive front end and the instruction memory write port. The fetcher is released via cpu_hold.

Parameters:
ADDR_W, 8, instruction memory address width (same as the fetcher's address width)
DATA_W, 32, instruction word width; fixed multiple of 8
BASE_ADDR, 0, first memory address written

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
byte_valid  in  1  byte_data is valid this cycle; single-cycle strobe per byte
byte_data  in  8  incoming stream byte
restart  in  1  synchronous request to re-arm the loader from DONE or ERROR
mem_we  out  1  instruction memory write enable, one-cycle pulse
mem_addr  out  ADDR_W  write address
mem_wdata  out  DATA_W  write data
cpu_hold  out  1  1 = keep the fetcher/processor in reset
load_done  out  1  program loaded and verified
load_error  out  1  load aborted (bad count or checksum)
words_loaded  out  ADDR_W+1  number of words written in the current load

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - cpu_hold=1, load_done=0, load_error=0, words_loaded=0.
  - Byte counter, word count and checksum are all 0.
- Frame format: count byte N, then N*4 data bytes, then one checksum byte.
  - Data bytes are sent MSB first: the first byte lands in wdata[31:24].
  - Checksum = XOR of all 4N data bytes. The count byte is not included.
- A byte is consumed only on a clk edge with byte_valid=1. Idle gaps of any length are allowed, as are back-to-back bytes every cycle.
- States:
  - IDLE
    - On a byte: N=byte_data.
    - N==0, or BASE_ADDR+N > 2**ADDR_W -> ERROR.
    - Otherwise -> DATA.
  - DATA
    - Each byte shifts into the packer and is XORed into the checksum; the 2-bit byte index increments.
    - On the 4th byte of a word, the next cycle has mem_we=1 with mem_wdata=packed word and mem_addr=current address.
    - The cycle after the pulse, mem_addr increments and words_loaded increments.
    - Write latency: one cycle from acceptance of the word's last byte to mem_we high.
    - When words_loaded reaches N (the last word's write issued) -> CHECK.
    - A byte arriving in the same cycle as mem_we is accepted normally; writes and byte intake overlap.
  - CHECK
    - On a byte: compare it to the checksum.
    - Equal -> DONE. load_done=1 and cpu_hold=0 from the next cycle.
    - Not equal -> ERROR. load_error=1, cpu_hold stays 1.
  - DONE / ERROR
    - Sticky; byte_valid is ignored.
    - restart=1 -> IDLE next cycle: clears load_done, load_error, words_loaded, checksum and byte index; mem_addr=BASE_ADDR; cpu_hold=1.
- restart in IDLE, DATA or CHECK aborts the frame and returns to IDLE with the same clears. restart has priority over a simultaneous byte.
- mem_we is never asserted outside DATA and never more than N times per frame.
- Reset mid-load returns to IDLE immediately. Memory contents already written are not erased.
- mem_wdata holds the last written word between pulses.
- mem_addr never wraps within a frame; the count check guarantees this.

Decomposition:
- Package loader_pkg:
  - state enum: IDLE, DATA, CHECK, DONE, ERROR
  - BYTES_PER_WORD = DATA_W/8
  - byte index width
- Sub-module instruction_loader_packer:
  - Shift register plus byte index and running XOR.
  - Inputs: clk, rst, clear, shift, byte_in.
  - Outputs: word_out, word_ready pulse, xor_out.

Test Plan:
1. rst, then stream 01, 12, 34, 56, 78, chk=0x08 -> mem_we one pulse with addr=0x00, wdata=0x12345678; then load_done=1, cpu_hold=0, words_loaded=1.
2. N=3, words 0xAABBCCDD, 0x00000001, 0xFFFFFFFF, correct XOR, random 0-5 cycle gaps -> three pulses at addr 0, 1, 2 with matching data; load_done=1.
3. N=2, valid data, wrong checksum -> both writes occur; load_error=1, load_done=0, cpu_hold=1; further bytes ignored.
4. Count byte 00 -> ERROR next cycle, no mem_we; restart then a valid 1-word frame -> load_done=1.
5. N=4, assert rst after 6 data bytes -> outputs return to reset values asynchronously; new 1-word frame -> write at addr 0, load_done=1.
6. Back-to-back bytes every cycle, N=2, restart pulsed together with the 5th data byte -> byte dropped, state IDLE, only one write occurred (addr 0).
